// File: rtl/la_capture_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : la_capture_engine_if                                         |
// | Description : Control, trigger and readback bundle of the capture engine. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface la_capture_engine_if #(
    parameter int CHANNEL_COUNT = 10,
    parameter int DEPTH         = 640,
    parameter int DIV_WIDTH     = 32,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int TRIG_W        = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
);
    logic [CHANNEL_COUNT-1:0] chan_enable;
    logic [CHANNEL_COUNT-1:0] chan_in;
    logic [DIV_WIDTH-1:0]     sample_div;
    logic [1:0]               trig_mode;
    logic [TRIG_W-1:0]        trig_channel;
    logic [CHANNEL_COUNT-1:0] trig_mask;
    logic [CHANNEL_COUNT-1:0] trig_pattern;
    logic [ADDR_W-1:0]        pretrig_count;
    logic                     arm;
    logic                     abort;
    logic [ADDR_W-1:0]        rd_addr;
    logic [CHANNEL_COUNT-1:0] rd_data;
    logic                     busy;
    logic                     done;
    logic                     triggered;

    modport master (
        output chan_enable, chan_in, sample_div, trig_mode, trig_channel,
               trig_mask, trig_pattern, pretrig_count, arm, abort, rd_addr,
        input  rd_data, busy, done, triggered
    );

    modport slave (
        input  chan_enable, chan_in, sample_div, trig_mode, trig_channel,
               trig_mask, trig_pattern, pretrig_count, arm, abort, rd_addr,
        output rd_data, busy, done, triggered
    );
endinterface
`default_nettype wire

// File: rtl/la_capture_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : la_capture_engine                                            |
// | Description : Armed single-shot triggered capture into a circular buffer, |
// |               read back by logical index with the oldest sample at 0.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module la_capture_engine #(
    parameter int CHANNEL_COUNT = 10,
    parameter int DEPTH         = 640,
    parameter int DIV_WIDTH     = 32,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int TRIG_W        = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    la_capture_engine_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

    state_t                   r_state;
    logic [CHANNEL_COUNT-1:0] r_sync1;
    logic [CHANNEL_COUNT-1:0] r_sync2;
    logic [CHANNEL_COUNT-1:0] r_prev;
    logic                     r_hist_valid;
    logic [DIV_WIDTH-1:0]     r_div_cnt;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [ADDR_W-1:0]        r_start_ptr;
    logic [ADDR_W-1:0]        r_pretrig;
    logic [ADDR_W-1:0]        r_pre_cnt;
    logic [ADDR_W-1:0]        r_post_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_triggered;
    logic [CHANNEL_COUNT-1:0] r_rd_data;
    logic [CHANNEL_COUNT-1:0] r_mem [DEPTH];

    logic [CHANNEL_COUNT-1:0] w_sample;
    logic                     w_tick;
    logic                     w_write;
    logic                     w_trig;
    logic [ADDR_W-1:0]        w_wr_next;
    logic [ADDR_W-1:0]        w_pretrig_clamp;
    logic [ADDR_W-1:0]        w_post_init;
    logic [ADDR_W-1:0]        w_pre_next;
    logic [ADDR_W:0]          w_phys_sum;
    logic [ADDR_W-1:0]        w_phys;
    logic                     w_rd_oob;

    assign w_sample        = r_sync2 & bus.chan_enable;
    assign w_tick          = r_busy && (r_div_cnt == bus.sample_div);
    assign w_write         = w_tick && !bus.abort;
    assign w_wr_next       = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
    assign w_pretrig_clamp = (bus.pretrig_count > c_last) ? c_last : bus.pretrig_count;
    assign w_post_init     = c_last - r_pretrig;
    assign w_pre_next      = r_pre_cnt + 1'b1;

    // Logical index is relative to the oldest sample; one conditional subtract wraps it.
    assign w_phys_sum = {1'b0, r_start_ptr} + {1'b0, bus.rd_addr};
    assign w_phys     = (w_phys_sum >= c_depth) ? ADDR_W'(w_phys_sum - c_depth)
                                                : ADDR_W'(w_phys_sum);
    assign w_rd_oob   = ({1'b0, bus.rd_addr} >= c_depth);

    always_comb begin
        w_trig = 1'b0;
        case (bus.trig_mode)
            2'd0:    w_trig = 1'b1;
            2'd1:    w_trig = r_hist_valid && !r_prev[bus.trig_channel] && w_sample[bus.trig_channel];
            2'd2:    w_trig = r_hist_valid && r_prev[bus.trig_channel] && !w_sample[bus.trig_channel];
            default: w_trig = ((w_sample ^ bus.trig_pattern) & bus.trig_mask) == '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && w_write) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_rd_oob) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_phys];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_prev       <= '0;
            r_hist_valid <= 1'b0;
            r_div_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_start_ptr  <= '0;
            r_pretrig    <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_triggered  <= 1'b0;
        end else begin
            r_sync1 <= bus.chan_in;
            r_sync2 <= r_sync1;

            if (r_busy && !w_tick) begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
            end

            if (w_write) begin
                r_wr_ptr     <= w_wr_next;
                r_prev       <= w_sample;
                r_hist_valid <= 1'b1;
            end

            if (bus.abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.arm) begin
                            r_pretrig    <= w_pretrig_clamp;
                            r_pre_cnt    <= '0;
                            r_triggered  <= 1'b0;
                            r_hist_valid <= 1'b0;
                            r_busy       <= 1'b1;
                            r_done       <= 1'b0;
                            r_state      <= (w_pretrig_clamp == '0) ? ST_WAIT : ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (w_tick) begin
                            r_pre_cnt <= w_pre_next;
                            if (w_pre_next == r_pretrig) begin
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (w_tick && w_trig) begin
                            r_triggered <= 1'b1;
                            // A full pre-trigger window leaves no post samples to take.
                            if (w_post_init == '0) begin
                                r_state     <= ST_DONE;
                                r_start_ptr <= w_wr_next;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                            end else begin
                                r_state    <= ST_POST;
                                r_post_cnt <= w_post_init;
                            end
                        end
                    end
                    ST_POST: begin
                        if (w_tick) begin
                            r_post_cnt <= r_post_cnt - 1'b1;
                            if (r_post_cnt == ADDR_W'(1)) begin
                                r_state     <= ST_DONE;
                                r_start_ptr <= w_wr_next;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.triggered = r_triggered;

endmodule
`default_nettype wire

// File: tb/tb_la_capture_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_la_capture_engine                                         |
// | Description : Scoreboard bench for the triggered capture engine.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_la_capture_engine;

    localparam int CH    = 10;
    localparam int DEPTH = 640;
    localparam int DIVW  = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = $clog2(CH);
    localparam int NS    = 2048;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    la_capture_engine_if #(.CHANNEL_COUNT(CH), .DEPTH(DEPTH), .DIV_WIDTH(DIVW)) bus ();

    la_capture_engine #(.CHANNEL_COUNT(CH), .DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [CH-1:0] stim  [NS];
    logic [CH-1:0] store [NS];
    logic [CH-1:0] en_before;
    logic [CH-1:0] en_after;
    int            en_switch;
    logic [CH-1:0] exp_q  [$];
    int            addr_q [$];

    function automatic logic [CH-1:0] en_of(input int k);
        return (k >= en_switch) ? en_after : en_before;
    endfunction

    function automatic void build_store();
        for (int k = 0; k < NS; k++) store[k] = stim[k] & en_of(k);
    endfunction

    // First ticked sample at or after the pre-trigger window that fires.
    function automatic int find_trigger(input int mode, input int ch, input logic [CH-1:0] mask,
                                        input logic [CH-1:0] pat, input int p);
        for (int k = p; k < NS; k++) begin
            case (mode)
                0:       return k;
                1:       if (k > 0 && !store[k-1][ch] && store[k][ch]) return k;
                2:       if (k > 0 && store[k-1][ch] && !store[k][ch]) return k;
                default: if ((store[k] & mask) == (pat & mask)) return k;
            endcase
        end
        return -1;
    endfunction

    task automatic set_cfg(input int mode, input int ch, input logic [CH-1:0] mask,
                           input logic [CH-1:0] pat, input int pc);
        bus.trig_mode     = 2'(mode);
        bus.trig_channel  = TW'(ch);
        bus.trig_mask     = mask;
        bus.trig_pattern  = pat;
        bus.pretrig_count = AW'(pc);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < NS; k++) stim[k] = CH'(k);
        en_before = '1;
        en_after  = '1;
        en_switch = NS;
    endtask

    // Sample k is presented right after the tick of sample k-1 (tick period is 4 cycles).
    task automatic arm_and_run(input int exp_ticks, input int max_m, input string name);
        int t_done;
        int k;
        t_done           = -1;
        bus.chan_in      = stim[0];
        bus.chan_enable  = en_of(0);
        bus.arm          = 1'b1;
        for (int m = 1; m <= max_m; m++) begin
            @(negedge clk);
            bus.arm = 1'b0;
            k = (m - 1) / 4;
            if (m > 1 && (m % 4) == 1 && k < NS) begin
                bus.chan_in     = stim[k];
                bus.chan_enable = en_of(k);
            end
            if (bus.done === 1'b1) begin
                t_done = m;
                break;
            end
        end
        checks++;
        if (exp_ticks >= 0) begin
            if (t_done !== 4 * exp_ticks + 1) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, t_done, 4 * exp_ticks + 1);
            end
        end else if (t_done !== -1) begin
            errors++;
            $display("FAIL %s unexpected_done: got cycle %0d expected none", name, t_done);
        end
    endtask

    task automatic read_all(input int base, input string name);
        int            a;
        logic [CH-1:0] e;
        logic [CH-1:0] got_exp;
        int            got_addr;
        for (int j = 0; j < DEPTH + 2; j++) begin
            if (j < DEPTH)       a = j;
            else if (j == DEPTH) a = DEPTH;
            else                 a = (1 << AW) - 1;
            if (a < DEPTH) e = store[base + a];
            else           e = '0;
            bus.rd_addr = AW'(a);
            exp_q.push_back(e);
            addr_q.push_back(a);
            @(negedge clk);
            got_exp  = exp_q.pop_front();
            got_addr = addr_q.pop_front();
            checks++;
            if (bus.rd_data !== got_exp) begin
                errors++;
                $display("FAIL %s rd_addr=%0d: got %h expected %h", name, got_addr, bus.rd_data, got_exp);
            end
        end
    endtask

    task automatic check_flags(input string name, input logic b, input logic d, input logic t);
        checks++;
        if ({bus.busy, bus.done, bus.triggered} !== {b, d, t}) begin
            errors++;
            $display("FAIL %s flags(busy,done,trig): got %b%b%b expected %b%b%b",
                     name, bus.busy, bus.done, bus.triggered, b, d, t);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.arm = 1'b1;
        repeat (3) @(negedge clk);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.rd_data !== '0) begin
            errors++;
            $display("FAIL reset rd_data: got %h expected 0", bus.rd_data);
        end
        reset   = 1'b0;
        bus.arm = 1'b0;
        repeat (8) @(negedge clk);
        check_flags("reset_no_rearm", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ramp_immediate();
        int t;
        int ticks;
        fill_ramp();
        build_store();
        set_cfg(0, 0, '0, '0, 0);
        t     = find_trigger(0, 0, '0, '0, 0);
        ticks = t + DEPTH;
        arm_and_run(ticks, 4 * ticks + 40, "ramp");
        check_flags("ramp_done", 1'b0, 1'b1, 1'b1);
        read_all(t, "ramp");
    endtask

    task automatic test_rising_edge();
        int t;
        int ticks;
        fill_ramp();
        for (int k = 0; k < NS; k++) stim[k][2] = (k >= 300);
        build_store();
        set_cfg(1, 2, '0, '0, 100);
        t     = find_trigger(1, 2, '0, '0, 100);
        ticks = t + DEPTH - 100;
        arm_and_run(ticks, 4 * ticks + 40, "rising");
        check_flags("rising_done", 1'b0, 1'b1, 1'b1);
        read_all(t - 100, "rising");
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_flags("abort_from_done", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_no_edge_abort();
        for (int k = 0; k < NS; k++) stim[k] = '1;
        en_before = '1;
        en_after  = '1;
        en_switch = NS;
        build_store();
        set_cfg(1, 2, '0, '0, 0);
        arm_and_run(-1, 200, "no_edge");
        check_flags("no_edge_wait", 1'b1, 1'b0, 1'b0);
        bus.abort = 1'b1;
        bus.arm   = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.arm   = 1'b0;
        check_flags("abort_wait", 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_flags("abort_stays_idle", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pattern_enable();
        int t;
        int ticks;
        for (int k = 0; k < NS; k++) stim[k] = CH'((k << 4) | 5);
        en_before = 10'h3FE;
        en_after  = 10'h3FF;
        en_switch = 20;
        build_store();
        set_cfg(3, 0, 10'h00F, 10'h005, 10);
        t     = find_trigger(3, 0, 10'h00F, 10'h005, 10);
        ticks = t + DEPTH - 10;
        arm_and_run(ticks, 4 * ticks + 40, "pattern");
        check_flags("pattern_done", 1'b0, 1'b1, 1'b1);
        read_all(t - 10, "pattern");
    endtask

    task automatic test_pretrig_clamp();
        int pc;
        int p;
        int t;
        int ticks;
        fill_ramp();
        build_store();
        pc = (DEPTH + 5) % (1 << AW);
        p  = (pc > DEPTH - 1) ? DEPTH - 1 : pc;
        set_cfg(0, 0, '0, '0, pc);
        t     = find_trigger(0, 0, '0, '0, p);
        ticks = t + DEPTH - p;
        arm_and_run(ticks, 4 * ticks + 40, "clamp_over");
        check_flags("clamp_over_done", 1'b0, 1'b1, 1'b1);
        read_all(t - p, "clamp_over");

        p = DEPTH - 1;
        set_cfg(3, 0, 10'h3FF, 10'd100, p);
        t     = find_trigger(3, 0, 10'h3FF, 10'd100, p);
        ticks = t + DEPTH - p;
        arm_and_run(ticks, 4 * ticks + 40, "clamp_full");
        check_flags("clamp_full_done", 1'b0, 1'b1, 1'b1);
        read_all(t - p, "clamp_full");
    endtask

    task automatic test_reset_midcapture();
        for (int k = 0; k < NS; k++) stim[k] = '0;
        en_before = '1;
        en_after  = '1;
        en_switch = NS;
        build_store();
        set_cfg(1, 2, '0, '0, 0);
        arm_and_run(-1, 40, "midcap");
        check_flags("midcap_busy", 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_flags("midcap_reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_flags("midcap_idle", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.chan_enable  = '1;
        bus.chan_in      = '0;
        bus.sample_div   = DIVW'(3);
        bus.trig_mode    = 2'd0;
        bus.trig_channel = '0;
        bus.trig_mask    = '0;
        bus.trig_pattern = '0;
        bus.pretrig_count = '0;
        bus.arm          = 1'b0;
        bus.abort        = 1'b0;
        bus.rd_addr      = '0;
        en_before        = '1;
        en_after         = '1;
        en_switch        = NS;
        @(negedge clk);
        test_reset();
        test_ramp_immediate();
        test_rising_edge();
        test_no_edge_abort();
        test_pattern_enable();
        test_pretrig_clamp();
        test_reset_midcapture();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
